// File: rtl/pacman_sprite_renderer_pkg.sv
// Shared types and constants for the Pac-Man sprite renderer.
//   dir_t         : sprite facing direction, also the ROM bank select
//   fetch_state_t : scanline prefetch FSM states
//   sprite_addr() : maps (direction, sprite row) to a sprite ROM address
package pacman_pkg;

  localparam int SPR_SIZE = 16;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_ADDR = 2'd1,
    FS_CAPT = 2'd2
  } fetch_state_t;

  // The ROM stores each direction's rows bottom-up, hence the inverted row.
  function automatic logic [6:0] sprite_addr(dir_t d, logic [3:0] row);
    return {1'b0, d, ~row};
  endfunction

endpackage

// File: rtl/pacman_sprite_renderer_shifter.sv
// sprite_line_shifter: holds one prefetched sprite row and serialises it
// onto pac_on_o as DrawX sweeps past the sprite's left column.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   pix_ce_i       : pixel enable; draw_x_i is meaningful only when high
//   draw_x_i       : current pixel column
//   sx_i           : latched sprite left column
//   load_i         : capture row_data_i into the line buffer, mark it valid
//   clear_i        : mark the line buffer invalid (no sprite on next line)
//   row_data_i     : sprite ROM row, bit 15 = leftmost pixel
//   pac_on_o       : registered opaque flag, one pixel tick after its column
module sprite_line_shifter
  import pacman_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pix_ce_i,
  input  logic [9:0]  draw_x_i,
  input  logic [9:0]  sx_i,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [15:0] row_data_i,
  output logic        pac_on_o
);

  logic [15:0] line_buf_q, line_buf_d;
  logic        line_valid_q, line_valid_d;
  // Bit 15 goes straight to pac_on on load, so only the remaining 15 bits
  // need to be held for shifting.
  logic [14:0] shreg_q, shreg_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pac_on_q, pac_on_d;

  always_comb begin
    line_buf_d   = line_buf_q;
    line_valid_d = line_valid_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    pac_on_d     = pac_on_q;

    if (load_i) begin
      line_buf_d   = row_data_i;
      line_valid_d = 1'b1;
    end else if (clear_i) begin
      line_valid_d = 1'b0;
    end

    if (pix_ce_i) begin
      if (draw_x_i < 10'(H_ACTIVE)) begin
        if (line_valid_q && (draw_x_i == sx_i)) begin
          shreg_d  = line_buf_q[14:0];
          cnt_d    = 4'd15;
          pac_on_d = line_buf_q[15];
        end else if (cnt_q != 4'd0) begin
          shreg_d  = {shreg_q[13:0], 1'b0};
          cnt_d    = cnt_q - 4'd1;
          pac_on_d = shreg_q[14];
        end else begin
          pac_on_d = 1'b0;
        end
      end else begin
        // Clearing the count at the right edge truncates the sprite
        // instead of letting it spill into the next line.
        pac_on_d = 1'b0;
        cnt_d    = 4'd0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_buf_q   <= '0;
      line_valid_q <= 1'b0;
      shreg_q      <= '0;
      cnt_q        <= '0;
      pac_on_q     <= 1'b0;
    end else begin
      line_buf_q   <= line_buf_d;
      line_valid_q <= line_valid_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      pac_on_q     <= pac_on_d;
    end
  end

  assign pac_on_o = pac_on_q;

endmodule

// File: rtl/pacman_sprite_renderer.sv
// pacman_sprite_renderer: per-pixel Pac-Man sprite renderer.
// Latches sprite position/direction once per frame, prefetches the next
// scanline's sprite row from the sprite ROM during hblank, and shifts it
// out as pac_on in step with DrawX.
//   Clk, Reset_n    : clock, asynchronous active-low reset
//   pix_ce          : pixel enable; DrawX/DrawY/frame_start are sampled
//                     only on Clk edges where pix_ce is high
//   DrawX, DrawY    : current pixel column / line
//   frame_start     : start-of-vblank pulse, latches pac_x/pac_y/pac_dir
//   pac_x,pac_y     : sprite top-left, game domain
//   pac_dir         : sprite direction (dir_t encoding)
//   rom_addr        : sprite ROM address, registered
//   rom_data        : sprite ROM row (combinational or 1-cycle registered)
//   pac_on          : sprite pixel opaque, one pixel tick after its DrawX
//   dbg_state_o     : fetch FSM state
module pacman_sprite_renderer
  import pacman_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        pix_ce,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        frame_start,
  input  logic [9:0]  pac_x,
  input  logic [9:0]  pac_y,
  input  logic [1:0]  pac_dir,
  output logic [6:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        pac_on,
  output logic [1:0]  dbg_state_o
);

  logic [9:0]   sx_q, sy_q;
  dir_t         sdir_q;
  fetch_state_t state_q, state_d;
  logic [6:0]   rom_addr_q, rom_addr_d;
  logic         line_load, line_clear;

  logic         fetch_trig;
  logic [9:0]   ny;
  logic [10:0]  row_s;
  logic         row_hit;

  // Shadow registers: the sprite moves only between frames, never mid-frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sx_q   <= '0;
      sy_q   <= '0;
      sdir_q <= LEFT;
    end else if (pix_ce && frame_start) begin
      sx_q   <= pac_x;
      sy_q   <= pac_y;
      sdir_q <= dir_t'(pac_dir);
    end
  end

  assign fetch_trig = pix_ce && (DrawX == 10'(H_ACTIVE));
  // Next line wraps from the last vblank line back to line 0.
  assign ny         = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
  // 11-bit difference: a negative row shows up as bit 10 set, so the
  // sprite is on the next line exactly when bits 10:4 are all zero.
  assign row_s      = {1'b0, ny} - {1'b0, sy_q};
  assign row_hit    = (row_s[10:4] == 7'd0) && (ny < 10'(V_ACTIVE));

  // Fetch FSM runs on every Clk so the 3-cycle fetch fits in hblank
  // regardless of the pixel rate. Triggers outside IDLE are ignored.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    line_load  = 1'b0;
    line_clear = 1'b0;
    case (state_q)
      FS_IDLE: begin
        if (fetch_trig) begin
          if (row_hit) begin
            state_d    = FS_ADDR;
            rom_addr_d = sprite_addr(sdir_q, row_s[3:0]);
          end else begin
            line_clear = 1'b1;
          end
        end
      end
      FS_ADDR: state_d = FS_CAPT;
      FS_CAPT: begin
        line_load = 1'b1;
        state_d   = FS_IDLE;
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= FS_IDLE;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  sprite_line_shifter u_shifter (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .pix_ce_i   (pix_ce),
    .draw_x_i   (DrawX),
    .sx_i       (sx_q),
    .load_i     (line_load),
    .clear_i    (line_clear),
    .row_data_i (rom_data),
    .pac_on_o   (pac_on)
  );

  assign rom_addr    = rom_addr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pacman_sprite_renderer.sv
// Testbench for pacman_sprite_renderer: directed scanline fragments with
// hand-computed rom_addr values and pac_on pixel ranges.
module tb_pacman_sprite_renderer;
  import pacman_pkg::*;

  // ---------------- clock / reset ----------------
  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        pix_ce;
  logic [9:0]  DrawX, DrawY;
  logic        frame_start;
  logic [9:0]  pac_x, pac_y;
  logic [1:0]  pac_dir;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data;
  logic        pac_on;
  logic [1:0]  dbg_state;

  always #5 Clk = ~Clk;

  pacman_sprite_renderer dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .pix_ce      (pix_ce),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .frame_start (frame_start),
    .pac_x       (pac_x),
    .pac_y       (pac_y),
    .pac_dir     (pac_dir),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pac_on      (pac_on),
    .dbg_state_o (dbg_state)
  );

  // 1-cycle registered ROM: returns rom_pat at rom_match (or everywhere
  // when rom_all is set), zero elsewhere.
  logic [15:0] rom_pat;
  logic [6:0]  rom_match;
  logic        rom_all;
  always @(posedge Clk)
    rom_data <= (rom_all || (rom_addr == rom_match)) ? rom_pat : 16'h0000;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every sampled pixel tick produces one pac_on value.
  always @(posedge Clk) begin
    if (Reset_n && pix_ce) begin
      #1;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pac_on x=%0d y=%0d: output tick with no expectation queued", DrawX, DrawY);
      end else begin
        chk($sformatf("pac_on x=%0d y=%0d", DrawX, DrawY), int'(pac_on), int'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pix(input int x, input int y, input bit fs, input bit exp_on);
    @(negedge Clk);
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    frame_start = fs;
    pix_ce      = 1'b1;
    exp_q.push_back(exp_on);
    @(negedge Clk);
    pix_ce      = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic frame(input int x, input int y, input dir_t d);
    pac_x   = 10'(x);
    pac_y   = 10'(y);
    pac_dir = d;
    pix(0, V_ACTIVE, 1'b1, 1'b0);
  endtask

  // pac_on expected high for on_lo <= x <= on_hi.
  task automatic draw(input int y, input int x0, input int x1, input int on_lo, input int on_hi);
    for (int x = x0; x <= x1; x++)
      pix(x, y, 1'b0, (x >= on_lo) && (x <= on_hi));
  endtask

  // Hblank of line y; hit says whether a fetch is expected to start.
  task automatic hblank(input int y, input bit hit, input int exp_addr);
    pix(H_ACTIVE, y, 1'b0, 1'b0);
    chk($sformatf("rom_addr hblank y=%0d", y), int'(rom_addr), exp_addr);
    chk($sformatf("fsm after trigger y=%0d", y), int'(dbg_state), hit ? 1 : 0);
    for (int x = H_ACTIVE + 1; x < H_ACTIVE + 4; x++)
      pix(x, y, 1'b0, 1'b0);
    chk($sformatf("fsm idle after fetch y=%0d", y), int'(dbg_state), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset_n = 1'b0; pix_ce = 1'b0; DrawX = '0; DrawY = '0; frame_start = 1'b0;
    pac_x = '0; pac_y = '0; pac_dir = '0;
    rom_pat = '0; rom_match = '0; rom_all = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset pac_on", int'(pac_on), 0);
    chk("reset rom_addr", int'(rom_addr), 0);
    chk("reset fsm", int'(dbg_state), 0);
    Reset_n = 1'b1;

    // Basic fetch and draw, RIGHT, row 2.
    rom_match = 7'h1D; rom_pat = 16'h03C0;
    frame(100, 50, RIGHT);
    hblank(51, 1'b1, 'h1D);
    draw(52, 96, 120, 106, 109);
    hblank(52, 1'b1, 'h1C);        // row 3: ROM returns zero
    draw(53, 96, 120, -1, -1);

    // Address mapping across directions and the row window edges.
    frame(100, 100, DOWN);
    hblank(109, 1'b1, 'h35);
    rom_match = 7'h0F; rom_pat = 16'h8000;
    frame(100, 100, LEFT);
    hblank(99, 1'b1, 'h0F);
    draw(100, 96, 110, 100, 100);
    hblank(98, 1'b0, 'h0F);        // row -1: no fetch, line invalidated
    draw(99, 96, 110, -1, -1);
    hblank(114, 1'b1, 'h00);       // row 15
    hblank(115, 1'b0, 'h00);       // row 16

    // Right clip: truncated at 639, no wrap into the next line.
    rom_all = 1'b1; rom_pat = 16'hFFFF;
    frame(630, 200, LEFT);
    hblank(200, 1'b1, 'h0E);
    draw(201, 620, 639, 630, 639);
    hblank(201, 1'b1, 'h0D);
    draw(202, 0, 20, -1, -1);

    // Bottom clip, then a sprite at line 0 fetched on the last vblank line.
    rom_all = 1'b0; rom_match = 7'h26; rom_pat = 16'h8001;
    frame(300, 470, UP);
    hblank(478, 1'b1, 'h26);
    draw(479, 296, 310, 300, 300);
    draw(479, 311, 320, 315, 315);
    hblank(479, 1'b0, 'h26);
    rom_match = 7'h2F;
    frame(300, 0, UP);
    hblank(524, 1'b1, 'h2F);
    draw(0, 296, 310, 300, 300);
    draw(0, 311, 320, 315, 315);

    // Position changes only take effect at frame_start.
    rom_match = 7'h1E; rom_pat = 16'h8000;
    frame(60, 20, RIGHT);
    pac_x = 10'd200;
    hblank(20, 1'b1, 'h1E);
    draw(21, 50, 70, 60, 60);
    draw(21, 195, 215, -1, -1);
    frame(200, 20, RIGHT);
    hblank(20, 1'b1, 'h1E);
    draw(21, 50, 70, -1, -1);
    draw(21, 195, 215, 200, 200);

    // Reset in the middle of a sprite (cnt = 8 after x=107).
    rom_all = 1'b1; rom_pat = 16'hFFFF;
    frame(100, 50, RIGHT);
    hblank(50, 1'b1, 'h1E);
    draw(51, 96, 107, 100, 107);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("mid-line reset pac_on", int'(pac_on), 0);
    chk("mid-line reset rom_addr", int'(rom_addr), 0);
    chk("mid-line reset fsm", int'(dbg_state), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    draw(51, 108, 130, -1, -1);

    repeat (4) @(negedge Clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
